led_shifter: RTL

LED_SHIFTER -- requirements
Module: led_shifter

---
 rtl/lamp_pkg.sv | 27 ++
 rtl/led_shifter_shift_reg.sv | 33 +++
 rtl/led_shifter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lamp_pkg.sv
// Shared definitions for the LED driver chain: default geometry,
// frame sequencer state encoding and a width helper.
package lamp_pkg;

  localparam int C_BITS     = 12;
  localparam int C_CHANNELS = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_SHIFT_HI = 3'd4,
    ST_LATCH    = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/led_shifter_shift_reg.sv
// Parallel-load, left-shift register holding the grayscale word being sent.
// Only the MSB leaves the block; it is the serial data bit.
module shift_reg
  import lamp_pkg::*;
#(
  parameter int c_width = C_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [c_width-1:0] din,
  output logic               msb
);

  logic [c_width-1:0] q_r;

  // Load wins over shift; zeros enter from the LSB side.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= {c_width{1'b0}};
    end else if (load) begin
      q_r <= din;
    end else if (shift) begin
      q_r <= q_r << 1;
    end else begin
      q_r <= q_r;
    end
  end

  assign msb = q_r[c_width-1];

endmodule

// File: rtl/led_shifter.sv
// Streams one framebuffer frame into a daisy chain of LED PWM drivers:
// words go out from the highest address down to 0, MSB first, two cycles
// per bit (clock low, then high), followed by a one-cycle latch pulse.
// The next word is fetched during the low half of the current word's last
// bit so the serial stream has no gaps between words.
module led_shifter
  import lamp_pkg::*;
#(
  parameter int c_ledboards = 30,
  parameter int c_channels  = C_CHANNELS,
  parameter int c_bits      = C_BITS
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic                                          i_start,
  output logic [width_of(c_ledboards*c_channels)-1:0]   o_addr,
  output logic                                          o_rd,
  input  logic [c_bits-1:0]                             i_data,
  output logic                                          o_clk,
  output logic                                          o_dai,
  output logic                                          o_lat,
  output logic                                          o_busy,
  output logic                                          o_done
);

  localparam int W  = c_ledboards * c_channels;
  localparam int AW = width_of(W);
  localparam int BW = width_of(c_bits);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(W - 1);
  localparam logic [AW-1:0] ADDR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
  localparam logic [BW-1:0] TOP_BIT    = BW'(c_bits - 1);
  localparam logic [BW-1:0] BIT_ZERO   = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  localparam logic          SINGLE_BIT = (c_bits == 1);

  state_t        state_r;
  logic [AW-1:0] addr_r;
  logic [BW-1:0] bitcnt_r;
  logic          pend_r;     // a prefetched word is arriving for the next reload
  logic          rd_r;
  logic          clk_r;
  logic          lat_r;
  logic          busy_r;
  logic          done_r;

  logic              prefetch_s;
  logic              sr_load_s;
  logic              sr_shift_s;
  logic [c_bits-1:0] sr_din_s;
  logic              sr_msb_s;

  // Decide whether the transition out of this cycle enters bit 0 of a word
  // that still has a lower address behind it, i.e. whether to issue a read.
  always_comb begin
    prefetch_s = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (SINGLE_BIT && (addr_r != ADDR_ZERO)) begin
          prefetch_s = 1'b1;
        end else begin
          prefetch_s = 1'b0;
        end
      end
      ST_SHIFT_HI: begin
        if ((bitcnt_r == BIT_ONE) && !SINGLE_BIT && (addr_r != ADDR_ZERO)) begin
          prefetch_s = 1'b1;
        end else if ((bitcnt_r == BIT_ZERO) && pend_r && SINGLE_BIT &&
                     (addr_r != ADDR_ZERO)) begin
          prefetch_s = 1'b1;
        end else begin
          prefetch_s = 1'b0;
        end
      end
      default: prefetch_s = 1'b0;
    endcase
  end

  // Shift register control: load fresh words, shift after each high half,
  // and clear it when the last bit is done so the data line idles low.
  always_comb begin
    sr_load_s  = 1'b0;
    sr_shift_s = 1'b0;
    sr_din_s   = {c_bits{1'b0}};
    case (state_r)
      ST_LOAD: begin
        sr_load_s = 1'b1;
        sr_din_s  = i_data;
      end
      ST_SHIFT_HI: begin
        if (bitcnt_r != BIT_ZERO) begin
          sr_shift_s = 1'b1;
        end else if (pend_r) begin
          sr_load_s = 1'b1;
          sr_din_s  = i_data;
        end else begin
          sr_load_s = 1'b1;
          sr_din_s  = {c_bits{1'b0}};
        end
      end
      default: begin
        sr_load_s  = 1'b0;
        sr_shift_s = 1'b0;
      end
    endcase
  end

  shift_reg #(
    .c_width (c_bits)
  ) u_shift_reg (
    .clk   (i_clk),
    .rst   (i_rst),
    .load  (sr_load_s),
    .shift (sr_shift_s),
    .din   (sr_din_s),
    .msb   (sr_msb_s)
  );

  // Frame sequencer: state, read address, bit counter and registered strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      addr_r   <= ADDR_ZERO;
      bitcnt_r <= BIT_ZERO;
      pend_r   <= 1'b0;
      rd_r     <= 1'b0;
      clk_r    <= 1'b0;
      lat_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          clk_r  <= 1'b0;
          lat_r  <= 1'b0;
          done_r <= 1'b0;
          if (i_start) begin
            state_r <= ST_FETCH;
            addr_r  <= LAST_ADDR;
            rd_r    <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            rd_r    <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        ST_FETCH: begin
          rd_r    <= 1'b0;
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          bitcnt_r <= TOP_BIT;
          clk_r    <= 1'b0;
          state_r  <= ST_SHIFT_LO;
          rd_r     <= prefetch_s;
          pend_r   <= prefetch_s;
          if (prefetch_s) begin
            addr_r <= addr_r - ADDR_ONE;
          end else begin
            addr_r <= addr_r;
          end
        end
        ST_SHIFT_LO: begin
          clk_r   <= 1'b1;
          rd_r    <= 1'b0;
          state_r <= ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          rd_r <= prefetch_s;
          if (prefetch_s) begin
            addr_r <= addr_r - ADDR_ONE;
          end else begin
            addr_r <= addr_r;
          end
          if (bitcnt_r != BIT_ZERO) begin
            bitcnt_r <= bitcnt_r - BIT_ONE;
            clk_r    <= 1'b0;
            state_r  <= ST_SHIFT_LO;
            pend_r   <= pend_r | prefetch_s;
          end else if (pend_r) begin
            bitcnt_r <= TOP_BIT;
            clk_r    <= 1'b0;
            state_r  <= ST_SHIFT_LO;
            pend_r   <= prefetch_s;
          end else begin
            clk_r    <= 1'b0;
            lat_r    <= 1'b1;
            state_r  <= ST_LATCH;
            pend_r   <= 1'b0;
          end
        end
        ST_LATCH: begin
          lat_r   <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          addr_r   <= ADDR_ZERO;
          bitcnt_r <= BIT_ZERO;
          pend_r   <= 1'b0;
          rd_r     <= 1'b0;
          clk_r    <= 1'b0;
          lat_r    <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign o_addr = addr_r;
  assign o_rd   = rd_r;
  assign o_clk  = clk_r;
  assign o_dai  = sr_msb_s;
  assign o_lat  = lat_r;
  assign o_busy = busy_r;
  assign o_done = done_r;

endmodule
